// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the iterative divider: state encoding and constants.
package div_iter_unit_pkg;

  // Widest operand width the constants below are sized for.
  localparam int DIV_MAX_WIDTH = 64;

  // Quotient returned for a zero divisor (all ones, sliced to the unit width).
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_Q = {DIV_MAX_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring-division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {2'b00, divisor};

  // Trial subtraction result decides the quotient bit and the new remainder.
  always_comb begin
    q_bit   = shifted[WIDTH+1] | ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for the EX stage. Produces one quotient
// bit per cycle and holds the pipeline through stallreq_for_div until done.
//
// Handshake: div_en is a one-cycle start accepted only in IDLE; the operands
// are latched at that edge and never looked at again. stallreq_for_div is high
// from the start cycle through the last iteration and drops in the DONE cycle,
// where result_valid pulses for one cycle with the final quotient/remainder.
// flush aborts everything and wins over div_en in the same cycle.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stallreq_for_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;     // dividend bits shift out MSB first, quotient bits shift in
  logic [WIDTH-1:0] dsr;     // |b|
  logic [WIDTH:0]   rem;     // partial remainder
  logic             sign_q;
  logic             sign_r;

  logic             b_zero;
  logic             last_iter;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign b_zero    = (b == '0);
  assign last_iter = (state == ST_ITER) && (cnt == CNT_W'(WIDTH - 1));
  assign a_abs     = (div_signed && a[WIDTH-1]) ? (-a) : a;
  assign b_abs     = (div_signed && b[WIDTH-1]) ? (-b) : b;
  assign q_raw     = {dvd[WIDTH-2:0], step_q};
  assign q_fix     = sign_q ? (-q_raw) : q_raw;
  assign r_fix     = sign_r ? (-step_rem[WIDTH-1:0]) : step_rem[WIDTH-1:0];

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem),
    .bit_in (dvd[WIDTH-1]),
    .divisor(dsr),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (div_en) state_nxt = b_zero ? ST_DONE : ST_ITER;
      ST_ITER: if (last_iter) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Outputs decoded from state; nothing asserted while held in reset.
  always_comb begin
    stallreq_for_div = resetn &
                       (((state == ST_IDLE) & div_en & ~flush) | (state == ST_ITER));
    result_valid     = (state == ST_DONE) & ~flush;
  end

  // Datapath: latch operands at start, iterate, write sign-fixed results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (div_en) begin
            if (b_zero) begin
              quotient  <= DIV_ZERO_Q[WIDTH-1:0];
              remainder <= a;
            end else begin
              dvd    <= a_abs;
              dsr    <= b_abs;
              rem    <= '0;
              cnt    <= '0;
              sign_q <= div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_r <= div_signed & a[WIDTH-1];
            end
          end
        end
        ST_ITER: begin
          dvd <= q_raw;
          rem <= step_rem;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
